// File: rtl/counter_pkg.sv
// Shared width default, count type and parameter sanity helpers for the
// free-running counter and its next-value logic.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

    // True when the terminal value fits in the counter width
    function automatic bit max_fits(input int width, input longint max_count);
        return (max_count >= 64'sd0) && (max_count < (64'sd1 <<< width));
    endfunction

    // True when the step is at least one and never skips a whole lap
    function automatic bit step_ok(input longint step, input longint max_count);
        return (step >= 64'sd1) && (step <= max_count);
    endfunction

    // True when the reset value lies inside the counting range
    function automatic bit reset_ok(input longint reset_value, input longint max_count);
        return (reset_value >= 64'sd0) && (reset_value <= max_count);
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-value logic: c+STEP, folded back into 0..MAX_COUNT when
// it passes the terminal value. The add is one bit wider than the count.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int STEP      = 1
) (
    input  logic [WIDTH-1:0] i_count,
    output logic [WIDTH-1:0] o_next
);

    // MAX_COUNT+1 can equal 2**WIDTH, so the modulus needs the extra bit too
    localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MAX_COUNT + 1);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_wrapped;

    // Widened add followed by a single conditional subtract for the wrap
    always_comb begin
        w_sum = {1'b0, i_count} + STEP_EXT;
        if (w_sum > MAX_EXT) begin
            w_wrapped = w_sum - MOD_EXT;
        end else begin
            w_wrapped = w_sum;
        end
        o_next = w_wrapped[WIDTH-1:0];
    end

endmodule

// File: rtl/counter.sv
// Free-running up-counter with synchronous active-high reset; count comes
// straight from the state register, so there is no path from reset to count.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNTER_WIDTH_DEFAULT,
    parameter int MAX_COUNT   = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0,
    parameter int STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Illegal configurations stop elaboration rather than producing a counter
    // that silently skips or overflows
    if (!max_fits(WIDTH, longint'(MAX_COUNT))) begin : g_bad_max
        $error("counter: MAX_COUNT must be below 2**WIDTH");
    end
    if (!reset_ok(longint'(RESET_VALUE), longint'(MAX_COUNT))) begin : g_bad_reset
        $error("counter: RESET_VALUE must not exceed MAX_COUNT");
    end
    if (!step_ok(longint'(STEP), longint'(MAX_COUNT))) begin : g_bad_step
        $error("counter: STEP must be in 1..MAX_COUNT");
    end

    counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .STEP      (STEP)
    ) u_next (
        .i_count (r_count),
        .o_next  (w_next)
    );

    // State register; reset takes priority over counting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VEC;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: a default instance (0..15, step 1) and a
// MAX_COUNT=9/STEP=3 instance share clk and reset.
module tb_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count_a;
    logic [3:0] count_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    int model_a = 0;
    int model_b = 0;
    bit model_valid = 1'b0;

    counter #(.WIDTH(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .count (count_a)
    );

    counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0), .STEP(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .count (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_next(input int c, input int max_count, input int step);
        int s;
        s = c + step;
        if (s > max_count) s = s - (max_count + 1);
        return s;
    endfunction

    // Drive reset on the falling edge, push the expected values for the next
    // rising edge, then return 1 ns after that edge
    task automatic drive_edge(input logic rst);
        @(negedge clk);
        reset = rst;
        if (rst) begin
            model_valid = 1'b1;
            model_a = 0;
            model_b = 0;
        end else if (model_valid) begin
            model_a = model_next(model_a, 15, 1);
            model_b = model_next(model_b, 9, 3);
        end
        if (model_valid) begin
            q_a.push_back(4'(model_a));
            q_b.push_back(4'(model_b));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        drive_edge(1'b0);
        drive_edge(1'b1);
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        n_checks++;
        if (count_a !== exp_a || count_a !== 4'd0) begin
            $display("FAIL reset_pulse: count=%0d expected=%0d at %0t", count_a, exp_a, $time);
        end else n_pass++;
        n_checks++;
        if (count_b !== exp_b) begin
            $display("FAIL reset_pulse_b: count=%0d expected=%0d", count_b, exp_b);
        end else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            drive_edge(1'b0);
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            n_checks++;
            if (count_a !== exp_a) begin
                $display("FAIL count_up[%0d]: count=%0d expected=%0d", i, count_a, exp_a);
            end else n_pass++;
            n_checks++;
            if (count_b !== exp_b) begin
                $display("FAIL count_up_b[%0d]: count=%0d expected=%0d", i, count_b, exp_b);
            end else n_pass++;
        end
        n_checks++;
        if (count_a !== 4'd10 || $time != 126) begin
            $display("FAIL count_at_125: count=%0d at %0t expected=10 at 126", count_a, $time);
        end else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_a;
        drive_edge(1'b1);
        exp_a = q_a.pop_front();
        void'(q_b.pop_front());
        n_checks++;
        if (count_a !== exp_a) begin
            $display("FAIL mid_reset: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            drive_edge(1'b0);
            exp_a = q_a.pop_front();
            void'(q_b.pop_front());
            n_checks++;
            if (count_a !== exp_a) begin
                $display("FAIL mid_restart[%0d]: count=%0d expected=%0d", i, count_a, exp_a);
            end else n_pass++;
        end
        n_checks++;
        if (count_a !== 4'd10 || $time != 236) begin
            $display("FAIL count_at_235: count=%0d at %0t expected=10 at 236", count_a, $time);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        drive_edge(1'b1);
        void'(q_a.pop_front());
        void'(q_b.pop_front());
        for (int i = 1; i <= 17; i++) begin
            drive_edge(1'b0);
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            n_checks++;
            if (count_a !== exp_a) begin
                $display("FAIL wrap[%0d]: count=%0d expected=%0d", i, count_a, exp_a);
            end else n_pass++;
            n_checks++;
            if (count_b !== exp_b) begin
                $display("FAIL wrap_b[%0d]: count=%0d expected=%0d", i, count_b, exp_b);
            end else n_pass++;
        end
        n_checks++;
        if (count_a !== 4'd1) begin
            $display("FAIL wrap_end: count=%0d expected=1", count_a);
        end else n_pass++;
    endtask

    task automatic test_held_reset();
        logic [3:0] exp_a;
        drive_edge(1'b0);
        void'(q_a.pop_front());
        void'(q_b.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b1);
            exp_a = q_a.pop_front();
            void'(q_b.pop_front());
            n_checks++;
            if (count_a !== exp_a) begin
                $display("FAIL held_reset[%0d]: count=%0d expected=%0d", i, count_a, exp_a);
            end else n_pass++;
            n_checks++;
            if (count_b !== 4'd0) begin
                $display("FAIL held_reset_b[%0d]: count=%0d expected=0", i, count_b);
            end else n_pass++;
        end
        drive_edge(1'b0);
        exp_a = q_a.pop_front();
        void'(q_b.pop_front());
        n_checks++;
        if (count_a !== exp_a) begin
            $display("FAIL held_release: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
    endtask

    task automatic test_nondefault();
        logic [3:0] seq_b [11];
        logic [3:0] exp_b;
        seq_b = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd0};
        for (int i = 0; i < 11; i++) begin
            drive_edge(i == 0 ? 1'b1 : 1'b0);
            void'(q_a.pop_front());
            exp_b = q_b.pop_front();
            n_checks++;
            if (count_b !== seq_b[i] || count_b !== exp_b) begin
                $display("FAIL step3_seq[%0d]: count=%0d expected=%0d", i, count_b, seq_b[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_on_wrap();
        logic [3:0] exp_a;
        drive_edge(1'b1);
        void'(q_a.pop_front());
        void'(q_b.pop_front());
        // reset on the edge that would otherwise load 15
        for (int i = 1; i <= 14; i++) begin
            drive_edge(1'b0);
            void'(q_a.pop_front());
            void'(q_b.pop_front());
        end
        drive_edge(1'b1);
        exp_a = q_a.pop_front();
        void'(q_b.pop_front());
        n_checks++;
        if (count_a !== exp_a) begin
            $display("FAIL reset_at_14: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
        // reset on the edge where count is already 15
        for (int i = 1; i <= 15; i++) begin
            drive_edge(1'b0);
            exp_a = q_a.pop_front();
            void'(q_b.pop_front());
        end
        n_checks++;
        if (count_a !== exp_a || count_a !== 4'd15) begin
            $display("FAIL reach_15: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
        drive_edge(1'b1);
        exp_a = q_a.pop_front();
        void'(q_b.pop_front());
        n_checks++;
        if (count_a !== exp_a) begin
            $display("FAIL reset_on_wrap: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
        drive_edge(1'b0);
        exp_a = q_a.pop_front();
        void'(q_b.pop_front());
        n_checks++;
        if (count_a !== exp_a || count_a !== 4'd1) begin
            $display("FAIL resume_after_wrap_reset: count=%0d expected=%0d", count_a, exp_a);
        end else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_mid_reset();
        test_wrap();
        test_held_reset();
        test_nondefault();
        test_reset_on_wrap();
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            $display("FAIL scoreboard_drain: left a=%0d b=%0d expected 0", q_a.size(), q_b.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
